// File: rtl/audio_record_playback_buf.sv
// ---------------------------------------------------------------------------
// audio_record_playback_buf
//
// Record/playback buffer for the audio path. Mic samples arrive with a 1-cycle
// ready_in strobe. Only every DECIM-th strobe is used. In RECORD the used
// samples are written to an internal single-port RAM. In PLAY they are read
// back at the same decimated rate and driven to the headphone PWM stage.
//
// Build option:
//   RECORDER_LOOP_EN  defined   : playback wraps to the start of the
//                                 recording and continues while play_in=1.
//                                 done_out pulses once per pass.
//                     undefined : playback stops at the end of the recording
//                                 and returns to IDLE. A new playback needs
//                                 play_in to go low and then high again.
//
// Ports:
//   clk_in      system clock; all state updates on its rising edge
//   rst_n_in    synchronous active-low reset
//   record_in   level, record request (wins over play_in)
//   play_in     level, playback request
//   ready_in    1-cycle strobe, mic_in valid
//   mic_in      signed mic sample
//   data_out    signed sample to headphone (record monitor / playback data)
//   state_out   0 IDLE, 1 RECORD, 2 PLAY
//   full_out    last recording filled the whole RAM
//   length_out  samples currently recorded, 0..2**ADDR_W
//   done_out    1-cycle pulse when playback reaches the end of the recording
// ---------------------------------------------------------------------------
module audio_record_playback_buf #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DECIM  = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     record_in,
  input  logic                     play_in,
  input  logic                     ready_in,
  input  logic signed [DATA_W-1:0] mic_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic [1:0]               state_out,
  output logic                     full_out,
  output logic [ADDR_W:0]          length_out,
  output logic                     done_out
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int DEPTH  = 2**ADDR_W;
`ifdef RECORDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [DCNT_W-1:0]        dcnt_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W:0]          len_q;
  logic                     full_q;
  logic                     done_q;
  logic                     block_q;    // playback locked until play_in drops
  logic                     src_ram_q;  // data_out shows RAM read data
  logic signed [DATA_W-1:0] mon_q;      // record monitor value, 0 otherwise
  logic signed [DATA_W-1:0] ram_q;
  logic signed [DATA_W-1:0] mem [DEPTH];

  logic accept, rec_last, rd_last, entering, wr_en, rd_en;

  assign accept   = ready_in && (dcnt_q == '0);
  assign rec_last = (len_q == (ADDR_W+1)'(DEPTH-1));
  // Read of the last recorded sample. Written as addr+1 == length so that a
  // completely full RAM (length = 2**ADDR_W) needs no special case.
  assign rd_last  = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == len_q);
  assign entering = (state_d != state_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (record_in)                                  state_d = S_REC;
        else if (play_in && len_q != '0 && !block_q)    state_d = S_PLAY;
      end
      S_REC: begin
        if (!record_in)              state_d = S_IDLE;
        else if (accept && rec_last) state_d = S_IDLE;  // RAM full, no wrap
      end
      S_PLAY: begin
        if (record_in)              state_d = S_REC;    // abort into new take
        else if (!play_in)          state_d = S_IDLE;
        else if (!LOOP && done_q)   state_d = S_IDLE;   // one-shot finished
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM strobes are held off during reset so that contents are kept.
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (rst_n_in) begin
      case (state_q)
        S_REC:   wr_en = record_in && accept;
        S_PLAY:  rd_en = (state_d == S_PLAY) && accept;
        default: ;
      endcase
    end
  end

  assign state_out = state_q;

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      dcnt_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      block_q   <= 1'b0;
      src_ram_q <= 1'b0;
      mon_q     <= '0;
    end else begin
      done_q <= 1'b0;

      // Decimation counter restarts on every state entry so the first
      // strobe in a new state is always used.
      if (entering)
        dcnt_q <= '0;
      else if (ready_in && state_q != S_IDLE)
        dcnt_q <= (dcnt_q == DCNT_W'(DECIM-1)) ? '0 : dcnt_q + DCNT_W'(1);

      if (entering && state_d == S_REC) begin
        addr_q <= '0;
        len_q  <= '0;
        full_q <= 1'b0;
      end else if (entering && state_d == S_PLAY) begin
        addr_q <= '0;
      end else if (wr_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        len_q  <= len_q + (ADDR_W+1)'(1);
        if (rec_last) full_q <= 1'b1;
      end else if (rd_en) begin
        addr_q <= rd_last ? '0 : addr_q + ADDR_W'(1);
        done_q <= rd_last;  // lands on the same cycle as the data
      end

      // The last write of a full take still shows on the monitor for one
      // cycle; IDLE clears the output on the following edge.
      if (wr_en) begin
        mon_q     <= mic_in;
        src_ram_q <= 1'b0;
      end else if (rd_en) begin
        src_ram_q <= 1'b1;
      end else if (entering || state_d == S_IDLE) begin
        mon_q     <= '0;
        src_ram_q <= 1'b0;
      end

      if (!play_in)
        block_q <= 1'b0;
      else if (!LOOP && state_q == S_PLAY && done_q)
        block_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- RAM
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[addr_q] <= mic_in;
    if (rd_en) ram_q <= mem[addr_q];
  end

  assign data_out   = src_ram_q ? ram_q : mon_q;
  assign full_out   = full_q;
  assign length_out = len_q;
  assign done_out   = done_q;

endmodule
